// File: rtl/hs_pc_sequencer.sv
// hs_pc_sequencer
// Program-counter sequencer for a switch-driven "manual computer": a number
// of handshaked input instructions, a free-running compute burst, then a
// number of handshaked output/display instructions, and back to address 0.
//
// Optional feature macro: HS_DEBOUNCE_EN
//   undefined : the accepted switch level is the 2-flop synchroniser output.
//   defined   : the synchroniser output must disagree with the accepted level
//               for DEB_CYCLES consecutive cycles before it is taken.
//
// Handshake semantics: the operator drives a level on sw. A wait-for-high
// state proceeds on the first cycle the accepted level is 1 (a level that is
// already high on entry counts immediately). A wait-for-low state proceeds
// on the first cycle it is 0. Nothing is edge-detected, and RUN ignores sw.
module hs_pc_sequencer #(
  parameter  int PSIZE      = 4,
  parameter  int NUM_IN     = 2,
  parameter  int NUM_OUT    = 2,
  parameter  int RUN_LEN    = 8,
  parameter  int DEB_CYCLES = 4,
  localparam int INW        = (NUM_IN  > 1) ? $clog2(NUM_IN)  : 1,
  localparam int OUTW       = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sw,
  input  logic             abort,
  output logic [PSIZE-1:0] pc,
  output logic             in_exec,
  output logic [INW-1:0]   in_idx,
  output logic             run_busy,
  output logic [OUTW-1:0]  out_idx,
  output logic             out_phase,
  output logic             idle
);

  localparam int RCW = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;

  // Parameter sanity: the whole program must fit below the top address so
  // that pc never wraps.
  if (2 * NUM_IN + RUN_LEN + NUM_OUT > (1 << PSIZE) - 1) begin : g_bad_size
    $error("hs_pc_sequencer: program does not fit in PSIZE-bit pc");
  end
  if (NUM_IN < 1 || NUM_IN > 8) begin : g_bad_num_in
    $error("hs_pc_sequencer: NUM_IN out of range 1..8");
  end
  if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
    $error("hs_pc_sequencer: NUM_OUT out of range 1..8");
  end
  if (RUN_LEN < 1 || RUN_LEN > (1 << PSIZE)) begin : g_bad_run_len
    $error("hs_pc_sequencer: RUN_LEN out of range");
  end
  if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("hs_pc_sequencer: DEB_CYCLES out of range 2..255");
  end

  typedef enum logic [2:0] {
    IN_WAIT_HI  = 3'd0,
    IN_EXEC     = 3'd1,
    IN_WAIT_LO  = 3'd2,
    RUN         = 3'd3,
    OUT_WAIT_HI = 3'd4,
    OUT_WAIT_LO = 3'd5,
    OUT_LAST_LO = 3'd6
  } state_e;

  // ---------------------------------------------------------------------
  // Switch input conditioning
  // ---------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic swa;

  // Two-flop synchroniser for the asynchronous switch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

`ifdef HS_DEBOUNCE_EN
  logic       deb_level_q;
  logic       deb_level_d;
  logic [7:0] deb_cnt_q;
  logic [7:0] deb_cnt_d;

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = 8'd0;
    if (sync2_q != deb_level_q) begin
      if (deb_cnt_q == 8'(DEB_CYCLES - 1)) begin
        deb_level_d = sync2_q;
        deb_cnt_d   = 8'd0;
      end else begin
        deb_cnt_d   = deb_cnt_q + 8'd1;
      end
    end
  end

  // Debounce state register; abort deliberately leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_level_q <= 1'b0;
      deb_cnt_q   <= 8'd0;
    end else begin
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  assign swa = deb_level_q;
`else
  assign swa = sync2_q;
`endif

  // ---------------------------------------------------------------------
  // Sequencer FSM and its datapath registers
  // ---------------------------------------------------------------------
  state_e           state_q,   state_d;
  logic [PSIZE-1:0] pc_q,      pc_d;
  logic [INW-1:0]   in_idx_q,  in_idx_d;
  logic [OUTW-1:0]  out_idx_q, out_idx_d;
  logic [RCW-1:0]   run_cnt_q, run_cnt_d;

  // State register together with pc, indices and the run counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IN_WAIT_HI;
      pc_q      <= '0;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Next-state logic; a "step" advances pc on the same edge as the move.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    run_cnt_d = run_cnt_q;

    unique case (state_q)
      IN_WAIT_HI: begin
        if (swa) begin
          state_d = IN_EXEC;
          pc_d    = pc_q + 1'b1;
        end
      end

      IN_EXEC: begin
        state_d = IN_WAIT_LO;
        pc_d    = pc_q + 1'b1;
      end

      IN_WAIT_LO: begin
        if (!swa) begin
          if (in_idx_q < INW'(NUM_IN - 1)) begin
            // Next input shares this release address as its wait address.
            state_d  = IN_WAIT_HI;
            in_idx_d = in_idx_q + 1'b1;
          end else begin
            state_d   = RUN;
            pc_d      = pc_q + 1'b1;
            run_cnt_d = '0;
          end
        end
      end

      RUN: begin
        pc_d = pc_q + 1'b1;
        if (run_cnt_q == RCW'(RUN_LEN - 1)) begin
          state_d   = OUT_WAIT_HI;
          out_idx_d = '0;
          run_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end

      OUT_WAIT_HI: begin
        if (swa) begin
          if (out_idx_q < OUTW'(NUM_OUT - 1)) begin
            state_d   = OUT_WAIT_LO;
            pc_d      = pc_q + 1'b1;
            out_idx_d = out_idx_q + 1'b1;
          end else begin
            // Last output: stay on this address until the switch drops.
            state_d = OUT_LAST_LO;
          end
        end
      end

      OUT_WAIT_LO: begin
        if (!swa) begin
          state_d = OUT_WAIT_HI;
        end
      end

      OUT_LAST_LO: begin
        if (!swa) begin
          state_d   = IN_WAIT_HI;
          pc_d      = '0;
          in_idx_d  = '0;
          out_idx_d = '0;
        end
      end

      default: begin
        state_d   = IN_WAIT_HI;
        pc_d      = '0;
        in_idx_d  = '0;
        out_idx_d = '0;
        run_cnt_d = '0;
      end
    endcase

    // Abort wins over whatever transition was computed above.
    if (abort) begin
      state_d   = IN_WAIT_HI;
      pc_d      = '0;
      in_idx_d  = '0;
      out_idx_d = '0;
      run_cnt_d = '0;
    end
  end

  // Output decode from the current state.
  always_comb begin
    in_exec   = 1'b0;
    run_busy  = 1'b0;
    out_phase = 1'b0;
    idle      = 1'b0;
    unique case (state_q)
      IN_WAIT_HI:  idle      = (in_idx_q == '0);
      IN_EXEC:     in_exec   = 1'b1;
      IN_WAIT_LO:  ;
      RUN:         run_busy  = 1'b1;
      OUT_WAIT_HI: out_phase = 1'b1;
      OUT_WAIT_LO: out_phase = 1'b1;
      OUT_LAST_LO: out_phase = 1'b1;
      default:     ;
    endcase
  end

  assign pc      = pc_q;
  assign in_idx  = in_idx_q;
  assign out_idx = out_idx_q;

endmodule
